// File: rtl/fc_rx_buffer.sv
// fc_rx_buffer: per-class receive FIFOs for the PCIe transaction layer.
// Each channel tracks its credits-allocated counter and returns freed
// credits through a round-robin arbitrated UpdateFC request handshake.
module fc_rx_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_CH       = 3,
  parameter int CREDIT_WIDTH = 8,
  parameter int UPD_THRESH   = 4,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [CW-1:0]             wr_ch,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      rd_en,
  input  logic [CW-1:0]             rd_ch,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid,
  output logic [NUM_CH-1:0]         full,
  output logic [NUM_CH-1:0]         empty,
  output logic [NUM_CH*CNT_W-1:0]   count,
  output logic [NUM_CH-1:0]         ovf_err,
  input  logic                      ovf_clr,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [CW-1:0]             upd_ch,
  output logic [CREDIT_WIDTH-1:0]   upd_credits
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q   [NUM_CH], wr_ptr_d   [NUM_CH];
  logic [PTR_W-1:0]        rd_ptr_q   [NUM_CH], rd_ptr_d   [NUM_CH];
  logic [CNT_W-1:0]        cnt_q      [NUM_CH], cnt_d      [NUM_CH];
  logic [CREDIT_WIDTH-1:0] cr_alloc_q [NUM_CH], cr_alloc_d [NUM_CH];
  logic [CREDIT_WIDTH-1:0] pending_q  [NUM_CH], pending_d  [NUM_CH];
  logic [DATA_WIDTH-1:0]   mem [NUM_CH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [NUM_CH-1:0]       ovf_q, ovf_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [CW-1:0]           upd_ch_q, upd_ch_d;
  logic [CREDIT_WIDTH-1:0] upd_credits_q, upd_credits_d;
  logic [CW-1:0]           rr_q, rr_d;

  logic [NUM_CH-1:0]       full_w, empty_w, wr_hit, wr_acc, rd_acc, ovf_set, req;
  logic                    wr_in_range, rd_in_range, upd_clear;
  logic                    sel_found;
  logic [CW-1:0]           sel_ch;
  logic [CREDIT_WIDTH-1:0] sel_credits;

  assign wr_in_range = (32'(wr_ch) < NUM_CH);
  assign rd_in_range = (32'(rd_ch) < NUM_CH);
  assign upd_clear   = (state_q == REQ) && upd_ready;

  // Per-channel status and accept decisions; a read frees the slot a same-cycle write needs.
  always_comb begin
    full_w  = '0;
    empty_w = '0;
    wr_hit  = '0;
    wr_acc  = '0;
    rd_acc  = '0;
    ovf_set = '0;
    req     = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      full_w[ch]  = (cnt_q[ch] == CNT_W'(FIFO_DEPTH));
      empty_w[ch] = (cnt_q[ch] == '0);
      rd_acc[ch]  = rd_en && rd_in_range && (rd_ch == CW'(ch)) && !empty_w[ch];
      wr_hit[ch]  = wr_en && wr_in_range && (wr_ch == CW'(ch));
      wr_acc[ch]  = wr_hit[ch] && (!full_w[ch] || rd_acc[ch]);
      ovf_set[ch] = wr_hit[ch] && full_w[ch] && !rd_acc[ch];
      req[ch]     = (pending_q[ch] >= CREDIT_WIDTH'(UPD_THRESH)) ||
                    ((pending_q[ch] != '0) && empty_w[ch]);
    end
  end

  // Next pointers, occupancy, credit counters and sticky overflow flags per channel.
  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr_ptr_d[ch]   = wr_ptr_q[ch] + PTR_W'(wr_acc[ch]);
      rd_ptr_d[ch]   = rd_ptr_q[ch] + PTR_W'(rd_acc[ch]);
      cnt_d[ch]      = cnt_q[ch] + CNT_W'(wr_acc[ch]) - CNT_W'(rd_acc[ch]);
      cr_alloc_d[ch] = cr_alloc_q[ch] + CREDIT_WIDTH'(rd_acc[ch]);
      pending_d[ch]  = pending_q[ch];
      if (rd_acc[ch] && (pending_q[ch] != {CREDIT_WIDTH{1'b1}})) begin
        pending_d[ch] = pending_q[ch] + CREDIT_WIDTH'(1);
      end
      if (upd_clear && (upd_ch_q == CW'(ch))) begin
        pending_d[ch] = CREDIT_WIDTH'(rd_acc[ch]);
      end
      ovf_d[ch] = ovf_clr ? 1'b0 : (ovf_q[ch] | ovf_set[ch]);
    end
  end

  // Registered read port: capture the head entry of the channel being read.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = |rd_acc;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_acc[ch]) begin
        data_out_d = mem[ch][rd_ptr_q[ch]];
      end
    end
  end

  // Round-robin pick plus the IDLE/REQ UpdateFC handshake.
  always_comb begin
    state_d       = state_q;
    upd_valid_d   = upd_valid_q;
    upd_ch_d      = upd_ch_q;
    upd_credits_d = upd_credits_q;
    rr_d          = rr_q;
    sel_found     = 1'b0;
    sel_ch        = '0;
    sel_credits   = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!sel_found && req[ch] && (CW'(ch) >= rr_q)) begin
        sel_found   = 1'b1;
        sel_ch      = CW'(ch);
        sel_credits = cr_alloc_d[ch];
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!sel_found && req[ch] && (CW'(ch) < rr_q)) begin
        sel_found   = 1'b1;
        sel_ch      = CW'(ch);
        sel_credits = cr_alloc_d[ch];
      end
    end
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d       = REQ;
          upd_valid_d   = 1'b1;
          upd_ch_d      = sel_ch;
          upd_credits_d = sel_credits;
        end
      end
      REQ: begin
        if (upd_ready) begin
          state_d     = IDLE;
          upd_valid_d = 1'b0;
          rr_d        = (upd_ch_q == CW'(NUM_CH - 1)) ? '0 : upd_ch_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry storage, written only on accepted writes; contents need no reset.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_acc[ch]) begin
        mem[ch][wr_ptr_q[ch]] <= data_in;
      end
    end
  end

  // State registers; reset restores the full initial credit advertisement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_out_q    <= '0;
      rd_valid_q    <= 1'b0;
      ovf_q         <= '0;
      upd_valid_q   <= 1'b0;
      upd_ch_q      <= '0;
      upd_credits_q <= '0;
      rr_q          <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        wr_ptr_q[ch]   <= '0;
        rd_ptr_q[ch]   <= '0;
        cnt_q[ch]      <= '0;
        cr_alloc_q[ch] <= CREDIT_WIDTH'(FIFO_DEPTH);
        pending_q[ch]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      data_out_q    <= data_out_d;
      rd_valid_q    <= rd_valid_d;
      ovf_q         <= ovf_d;
      upd_valid_q   <= upd_valid_d;
      upd_ch_q      <= upd_ch_d;
      upd_credits_q <= upd_credits_d;
      rr_q          <= rr_d;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        wr_ptr_q[ch]   <= wr_ptr_d[ch];
        rd_ptr_q[ch]   <= rd_ptr_d[ch];
        cnt_q[ch]      <= cnt_d[ch];
        cr_alloc_q[ch] <= cr_alloc_d[ch];
        pending_q[ch]  <= pending_d[ch];
      end
    end
  end

  // Pack per-channel occupancy with channel 0 in the low bits.
  always_comb begin
    count = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      count[ch*CNT_W +: CNT_W] = cnt_q[ch];
    end
  end

  assign full        = full_w;
  assign empty       = empty_w;
  assign data_out    = data_out_q;
  assign rd_valid    = rd_valid_q;
  assign ovf_err     = ovf_q;
  assign upd_valid   = upd_valid_q;
  assign upd_ch      = upd_ch_q;
  assign upd_credits = upd_credits_q;

endmodule

// File: tb/tb_fc_rx_buffer.sv
// Directed testbench for fc_rx_buffer with hand-computed expected values.
module tb_fc_rx_buffer;

   localparam int DW   = 8;
   localparam int DEPTH = 16;
   localparam int NCH  = 3;
   localparam int CRW  = 8;
   localparam int THR  = 4;
   localparam int CW   = 2;
   localparam int CNTW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              wr_en;
   logic [CW-1:0]     wr_ch;
   logic [DW-1:0]     data_in;
   logic              rd_en;
   logic [CW-1:0]     rd_ch;
   logic [DW-1:0]     data_out;
   logic              rd_valid;
   logic [NCH-1:0]    full;
   logic [NCH-1:0]    empty;
   logic [NCH*CNTW-1:0] count;
   logic [NCH-1:0]    ovf_err;
   logic              ovf_clr;
   logic              upd_valid;
   logic              upd_ready;
   logic [CW-1:0]     upd_ch;
   logic [CRW-1:0]    upd_credits;

   int vecCount = 0;
   int failCount = 0;
   int grantCh[$];
   int grantCr[$];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   fc_rx_buffer #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH),
      .CREDIT_WIDTH(CRW), .UPD_THRESH(THR)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_ch(wr_ch), .data_in(data_in),
      .rd_en(rd_en), .rd_ch(rd_ch),
      .data_out(data_out), .rd_valid(rd_valid),
      .full(full), .empty(empty), .count(count),
      .ovf_err(ovf_err), .ovf_clr(ovf_clr),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_ch(upd_ch), .upd_credits(upd_credits)
   );

   // Single comparison point: counts every vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Occupancy of one channel pulled out of the packed count bus.
   function automatic logic [CNTW-1:0] chCount(input int ch);
      return count[ch*CNTW +: CNTW];
   endfunction

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of write/read requests and let the edge consume them.
   task automatic applyStimulus(input logic we, input int wch, input logic [DW-1:0] din,
                                input logic re, input int rch);
      wr_en   = we;
      wr_ch   = CW'(wch);
      data_in = din;
      rd_en   = re;
      rd_ch   = CW'(rch);
      tick();
   endtask

   // Idle cycles with no traffic.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 8'h00, 1'b0, 0);
   endtask

   // Hold reset across one edge with all inputs quiet, then release it.
   task automatic applyReset();
      rst_n     = 1'b0;
      wr_en     = 1'b0;
      wr_ch     = '0;
      data_in   = '0;
      rd_en     = 1'b0;
      rd_ch     = '0;
      ovf_clr   = 1'b0;
      upd_ready = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // Wait a bounded number of cycles for an UpdateFC request; timing out is a miscompare.
   task automatic waitUpd(input string tag, input int maxCycles);
      int n;
      n = 0;
      while (!upd_valid && n < maxCycles) begin
         idleCycles(1);
         n++;
      end
      checkOutput(tag, 32'(upd_valid), 32'd1);
   endtask

   // Watchdog so the run always ends even if something stalls unexpectedly.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      int tmpCh;
      int tmpCr;

      $display("[TB] reset and idle");
      applyReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rstEmpty", 32'(empty), 32'h7);
      checkOutput("rstFull", 32'(full), 32'h0);
      checkOutput("rstCount", 32'(count), 32'h0);
      checkOutput("rstDataOut", 32'(data_out), 32'h0);
      checkOutput("rstRdValid", 32'(rd_valid), 32'h0);
      checkOutput("rstOvf", 32'(ovf_err), 32'h0);
      checkOutput("rstUpdValid", 32'(upd_valid), 32'h0);
      checkOutput("rstUpdCh", 32'(upd_ch), 32'h0);
      checkOutput("rstUpdCredits", 32'(upd_credits), 32'h0);
      rst_n = 1'b1;
      idleCycles(5);
      checkOutput("idleNoUpd", 32'(upd_valid), 32'h0);
      checkOutput("idleEmpty", 32'(empty), 32'h7);
      applyStimulus(1'b0, 0, 8'h00, 1'b1, 0);
      checkOutput("emptyRdValid", 32'(rd_valid), 32'h0);
      checkOutput("emptyRdHold", 32'(data_out), 32'h0);

      $display("[TB] fill and drain channel 1");
      applyReset();
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1, 8'(8'h10 + i), 1'b0, 0);
      checkOutput("fillCount1", 32'(chCount(1)), 32'd16);
      checkOutput("fillFull", 32'(full), 32'h2);
      checkOutput("fillNoOvf", 32'(ovf_err), 32'h0);
      applyStimulus(1'b1, 1, 8'hAA, 1'b0, 0);
      checkOutput("ovfSet", 32'(ovf_err), 32'h2);
      checkOutput("ovfCount1", 32'(chCount(1)), 32'd16);
      ovf_clr = 1'b1;
      applyStimulus(1'b1, 1, 8'hBB, 1'b0, 0);
      ovf_clr = 1'b0;
      checkOutput("ovfClrPriority", 32'(ovf_err), 32'h0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b1, 1);
         checkOutput("drainValid", 32'(rd_valid), 32'h1);
         checkOutput("drainData", 32'(data_out), 32'(8'h10 + i));
      end
      applyStimulus(1'b0, 0, 8'h00, 1'b1, 1);
      checkOutput("drainDoneValid", 32'(rd_valid), 32'h0);
      checkOutput("drainDoneHold", 32'(data_out), 32'h1F);
      checkOutput("drainEmpty", 32'(empty), 32'h7);

      $display("[TB] out-of-range access and full-channel read/write");
      applyReset();
      applyStimulus(1'b1, 3, 8'h99, 1'b1, 3);
      checkOutput("oorCount", 32'(count), 32'h0);
      checkOutput("oorRdValid", 32'(rd_valid), 32'h0);
      checkOutput("oorOvf", 32'(ovf_err), 32'h0);
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 0, 8'(8'h20 + i), 1'b0, 0);
      checkOutput("fullCount0", 32'(chCount(0)), 32'd16);
      checkOutput("fullFlag0", 32'(full), 32'h1);
      applyStimulus(1'b1, 0, 8'h55, 1'b1, 0);
      checkOutput("rwValid", 32'(rd_valid), 32'h1);
      checkOutput("rwData", 32'(data_out), 32'h20);
      checkOutput("rwCount", 32'(chCount(0)), 32'd16);
      checkOutput("rwNoOvf", 32'(ovf_err), 32'h0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 0, 8'h00, 1'b1, 0);
         checkOutput("rwDrainData", 32'(data_out), (i < 15) ? 32'(8'h21 + i) : 32'h55);
      end
      checkOutput("rwDrainCount", 32'(chCount(0)), 32'd0);

      $display("[TB] credit threshold and drain update");
      applyReset();
      upd_ready = 1'b1;
      applyStimulus(1'b1, 0, 8'h40, 1'b1, 0);
      checkOutput("noFallThrough", 32'(rd_valid), 32'h0);
      checkOutput("noFallCount", 32'(chCount(0)), 32'd1);
      for (int i = 1; i < 6; i++) applyStimulus(1'b1, 0, 8'(8'h40 + i), 1'b0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1, 0);
      checkOutput("thrNotYet", 32'(upd_valid), 32'h0);
      waitUpd("thrUpd", 8);
      checkOutput("thrCh", 32'(upd_ch), 32'd0);
      checkOutput("thrCredits", 32'(upd_credits), 32'd20);
      idleCycles(1);
      checkOutput("thrHandshake", 32'(upd_valid), 32'h0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1, 0);
      checkOutput("drainEmpty0", 32'(empty[0]), 32'h1);
      waitUpd("drainUpd", 8);
      checkOutput("drainUpdCh", 32'(upd_ch), 32'd0);
      checkOutput("drainUpdCredits", 32'(upd_credits), 32'd22);
      idleCycles(4);
      checkOutput("drainNoRepeat", 32'(upd_valid), 32'h0);

      $display("[TB] arbitration under backpressure");
      applyReset();
      for (int i = 0; i < 5; i++)
         for (int ch = 0; ch < 3; ch++) applyStimulus(1'b1, ch, 8'(ch * 16 + i), 1'b0, 0);
      for (int ch = 0; ch < 3; ch++)
         for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1, ch);
      for (int k = 0; k < 5; k++) begin
         idleCycles(1);
         checkOutput("bpValid", 32'(upd_valid), 32'h1);
         checkOutput("bpCh", 32'(upd_ch), 32'd0);
         checkOutput("bpCredits", 32'(upd_credits), 32'd20);
      end
      upd_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (upd_valid && upd_ready) begin
            grantCh.push_back(int'(upd_ch));
            grantCr.push_back(int'(upd_credits));
         end
         idleCycles(1);
      end
      checkOutput("grantCount", 32'(grantCh.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         tmpCh = (i < grantCh.size()) ? grantCh[i] : -1;
         tmpCr = (i < grantCr.size()) ? grantCr[i] : -1;
         checkOutput("grantOrder", 32'(tmpCh), 32'(i));
         checkOutput("grantCredits", 32'(tmpCr), 32'd20);
      end

      $display("[TB] credit wrap and mid-request reset");
      applyReset();
      upd_ready = 1'b1;
      for (int b = 0; b < 60; b++) begin
         for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, 8'(b * 4 + i), 1'b0, 0);
         if (b == 59) upd_ready = 1'b0;
         for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1, 2);
      end
      waitUpd("wrapUpd", 8);
      checkOutput("wrapCh", 32'(upd_ch), 32'd2);
      checkOutput("wrapCredits", 32'(upd_credits), 32'd0);
      idleCycles(1);
      checkOutput("wrapHeld", 32'(upd_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstValid", 32'(upd_valid), 32'h0);
      checkOutput("midRstCredits", 32'(upd_credits), 32'h0);
      checkOutput("midRstEmpty", 32'(empty), 32'h7);
      tick();
      rst_n = 1'b1;
      upd_ready = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2, 8'(8'h70 + i), 1'b0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 8'h00, 1'b1, 2);
      waitUpd("postRstUpd", 8);
      checkOutput("postRstCh", 32'(upd_ch), 32'd2);
      checkOutput("postRstCredits", 32'(upd_credits), 32'd20);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
